// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: owns pc/ir, walks FETCH-DECODE-EXEC-[MEM]-[WB] per instruction.
// Latency: BEQ/JMP/illegal 3 cycles, ALU 4, STORE 4+waits, LOAD 5+waits; retire/illegal_op pulse the cycle after completion.
// Backpressure: MEM holds dmem_req/dmem_we/alu_src_imm stable for as long as dmem_ready stays low, with no cycle limit.
module cpu_ctrl_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  OP_ALUR  = 5'h00,
    parameter logic [4:0]  OP_ALUI  = 5'h01,
    parameter logic [4:0]  OP_LOAD  = 5'h02,
    parameter logic [4:0]  OP_STORE = 5'h03,
    parameter logic [4:0]  OP_BEQ   = 5'h04,
    parameter logic [4:0]  OP_JMP   = 5'h05,
    parameter logic [4:0]  OP_HALT  = 5'h1F
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    input  logic [31:0] imm_ext,
    input  logic        alu_zero,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        wb_sel_mem,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic        illegal_op,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } fsmState;

    fsmState     state;
    fsmState     stateNext;
    logic [31:0] pcNext;
    logic [31:0] irNext;
    logic        retireNext;
    logic        illegalNext;

    logic [4:0]  opcode;
    logic [31:0] pcPlusOne;
    logic [31:0] pcPlusImm;
    logic        isLoad;
    logic        isStore;

    // Opcode field and the two pc candidates; both sums wrap modulo 2^32.
    assign opcode    = ir[31:27];
    assign pcPlusOne = pc + 32'd1;
    assign pcPlusImm = pc + imm_ext;
    assign isLoad    = (opcode == OP_LOAD);
    assign isStore   = (opcode == OP_STORE);
    assign imem_addr = pc;

    // State, pc, ir and the completion pulses; reset overrides every update, including a pending dmem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= 32'h0;
            retire     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            ir         <= irNext;
            retire     <= retireNext;
            illegal_op <= illegalNext;
        end
    end

    // Next-state, next pc/ir and datapath strobes, decoded from the current state and the latched opcode.
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        irNext      = ir;
        retireNext  = 1'b0;
        illegalNext = 1'b0;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        wb_sel_mem  = 1'b0;
        reg_we      = 1'b0;
        halted      = 1'b0;

        case (state)
            FETCH: begin
                stateNext = DECODE;
            end

            DECODE: begin
                // Sync ROM data for pc is valid now.
                irNext    = imem_data;
                stateNext = EXEC;
            end

            EXEC: begin
                case (opcode)
                    OP_ALUR: begin
                        stateNext = WB;
                    end
                    OP_ALUI: begin
                        alu_src_imm = 1'b1;
                        stateNext   = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        // ALU forms rs + imm_ext as the data address.
                        alu_src_imm = 1'b1;
                        stateNext   = MEM;
                    end
                    OP_BEQ: begin
                        // ALU compares two registers, so operand B stays on the regfile.
                        pcNext     = alu_zero ? pcPlusImm : pcPlusOne;
                        retireNext = 1'b1;
                        stateNext  = FETCH;
                    end
                    OP_JMP: begin
                        pcNext     = pcPlusImm;
                        retireNext = 1'b1;
                        stateNext  = FETCH;
                    end
                    OP_HALT: begin
                        stateNext = HALT;
                    end
                    default: begin
                        // Undefined opcode behaves as a NOP that also flags itself.
                        illegalNext = 1'b1;
                        retireNext  = 1'b1;
                        pcNext      = pcPlusOne;
                        stateNext   = FETCH;
                    end
                endcase
            end

            MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = isStore;
                alu_src_imm = 1'b1;
                if (dmem_ready) begin
                    if (isStore) begin
                        pcNext     = pcPlusOne;
                        retireNext = 1'b1;
                        stateNext  = FETCH;
                    end else begin
                        stateNext = WB;
                    end
                end
            end

            WB: begin
                reg_we      = 1'b1;
                wb_sel_mem  = isLoad;
                alu_src_imm = (opcode == OP_ALUI) || isLoad;
                pcNext      = pcPlusOne;
                retireNext  = 1'b1;
                stateNext   = FETCH;
            end

            HALT: begin
                // Parked until reset; all strobes stay low.
                halted = 1'b1;
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks a fixed instruction sequence and checks each strobe cycle by cycle.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Ends with one summary line of check and error counts.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [31:0] imm_ext;
    logic        alu_zero;
    logic        alu_src_imm;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        wb_sel_mem;
    logic        reg_we;
    logic [31:0] pc;
    logic        retire;
    logic        illegal_op;
    logic        halted;

    int checks = 0;
    int errors = 0;

    cpu_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ir         (ir),
        .imm_ext    (imm_ext),
        .alu_zero   (alu_zero),
        .alu_src_imm(alu_src_imm),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .wb_sel_mem (wb_sel_mem),
        .reg_we     (reg_we),
        .pc         (pc),
        .retire     (retire),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered in FETCH; leaves the FSM in EXEC with the given word latched.
    task automatic fetchInstr(input string tag, input logic [31:0] expPc,
                              input logic [31:0] instr, input logic [31:0] ext);
        chk({tag, ".imem_addr"}, imem_addr, expPc);
        tick();
        chk({tag, ".retire_in_decode"}, {31'b0, retire}, 32'd0);
        imem_data = instr;
        imm_ext   = ext;
        tick();
        chk({tag, ".ir"}, ir, instr);
    endtask

    initial begin
        reset      = 1'b1;
        imem_data  = 32'h0;
        imm_ext    = 32'h0;
        alu_zero   = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.pc", pc, 32'h0);
        chk("rst.ir", ir, 32'h0);
        chk("rst.strobes",
            {24'b0, reg_we, dmem_req, dmem_we, alu_src_imm, wb_sel_mem, retire, illegal_op, halted},
            32'd0);
        reset = 1'b0;

        // JMP +0x10 from 0 to reach pc=0x10
        fetchInstr("jmp10", 32'h0, 32'h2800_0010, 32'h0000_0010);
        tick();
        chk("jmp10.pc", pc, 32'h10);
        chk("jmp10.retire", {31'b0, retire}, 32'd1);

        // ALUI at 0x10
        fetchInstr("alui", 32'h10, 32'h0800_0005, 32'h0000_0005);
        chk("alui.exec_src", {31'b0, alu_src_imm}, 32'd1);
        chk("alui.exec_we", {31'b0, reg_we}, 32'd0);
        tick();
        chk("alui.wb_we", {31'b0, reg_we}, 32'd1);
        chk("alui.wb_src", {31'b0, alu_src_imm}, 32'd1);
        chk("alui.wb_selmem", {31'b0, wb_sel_mem}, 32'd0);
        chk("alui.wb_pc", pc, 32'h10);
        tick();
        chk("alui.pc", pc, 32'h11);
        chk("alui.retire", {31'b0, retire}, 32'd1);
        chk("alui.we_off", {31'b0, reg_we}, 32'd0);

        // LOAD at 0x11, ready arrives in the 4th MEM cycle
        fetchInstr("load", 32'h11, 32'h1000_0004, 32'h0000_0004);
        chk("load.exec_req", {31'b0, dmem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("load.mem_req", {31'b0, dmem_req}, 32'd1);
            chk("load.mem_we", {31'b0, dmem_we}, 32'd0);
            chk("load.mem_retire", {31'b0, retire}, 32'd0);
            if (i == 3) dmem_ready = 1'b1;
        end
        tick();
        dmem_ready = 1'b0;
        chk("load.wb_req", {31'b0, dmem_req}, 32'd0);
        chk("load.wb_we", {31'b0, reg_we}, 32'd1);
        chk("load.wb_selmem", {31'b0, wb_sel_mem}, 32'd1);
        tick();
        chk("load.pc", pc, 32'h12);
        chk("load.retire", {31'b0, retire}, 32'd1);

        // JMP -2 back to 0x10
        fetchInstr("jmpm2", 32'h12, 32'h2FFF_FFFE, 32'hFFFF_FFFE);
        tick();
        chk("jmpm2.pc", pc, 32'h10);

        // BEQ taken, imm -2
        alu_zero = 1'b1;
        fetchInstr("beqt", 32'h10, 32'h27FF_FFFE, 32'hFFFF_FFFE);
        chk("beqt.src", {31'b0, alu_src_imm}, 32'd0);
        chk("beqt.we", {31'b0, reg_we}, 32'd0);
        tick();
        alu_zero = 1'b0;
        chk("beqt.pc", pc, 32'h0E);
        chk("beqt.retire", {31'b0, retire}, 32'd1);
        chk("beqt.we_after", {31'b0, reg_we}, 32'd0);

        // JMP +2 back to 0x10, then BEQ not taken
        fetchInstr("jmp2", 32'h0E, 32'h2800_0002, 32'h0000_0002);
        tick();
        chk("jmp2.pc", pc, 32'h10);
        fetchInstr("beqn", 32'h10, 32'h27FF_FFFE, 32'hFFFF_FFFE);
        chk("beqn.we", {31'b0, reg_we}, 32'd0);
        tick();
        chk("beqn.pc", pc, 32'h11);

        // JMP to 0xFFFF_FFFF, then JMP +2 wraps to 1
        fetchInstr("jmpmax", 32'h11, 32'h2FFF_FFEE, 32'hFFFF_FFEE);
        tick();
        chk("jmpmax.pc", pc, 32'hFFFF_FFFF);
        fetchInstr("jmpwrap", 32'hFFFF_FFFF, 32'h2800_0002, 32'h0000_0002);
        tick();
        chk("jmpwrap.pc", pc, 32'h1);
        chk("jmpwrap.retire", {31'b0, retire}, 32'd1);

        // Illegal opcode 0x0A treated as NOP
        fetchInstr("ill", 32'h1, 32'h5000_0000, 32'h0);
        chk("ill.exec_pulse", {31'b0, illegal_op}, 32'd0);
        tick();
        chk("ill.pc", pc, 32'h2);
        chk("ill.pulse", {31'b0, illegal_op}, 32'd1);
        chk("ill.retire", {31'b0, retire}, 32'd1);
        tick();
        chk("ill.pulse_off", {31'b0, illegal_op}, 32'd0);

        // Back in FETCH is not where we are: restart from reset before STORE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2.pc", pc, 32'h0);

        // STORE interrupted by reset while waiting on dmem_ready
        fetchInstr("st", 32'h0, 32'h1800_0004, 32'h0000_0004);
        chk("st.exec_src", {31'b0, alu_src_imm}, 32'd1);
        tick();
        chk("st.mem_req", {31'b0, dmem_req}, 32'd1);
        chk("st.mem_we", {31'b0, dmem_we}, 32'd1);
        tick();
        chk("st.mem_req2", {31'b0, dmem_req}, 32'd1);
        reset      = 1'b1;
        dmem_ready = 1'b1;
        tick();
        chk("st.rst_req", {31'b0, dmem_req}, 32'd0);
        chk("st.rst_we", {31'b0, dmem_we}, 32'd0);
        chk("st.rst_pc", pc, 32'h0);
        chk("st.rst_retire", {31'b0, retire}, 32'd0);
        reset      = 1'b0;
        dmem_ready = 1'b0;

        // HALT, then poke inputs; nothing may move
        fetchInstr("halt", 32'h0, 32'hF800_0000, 32'h0);
        chk("halt.exec_halted", {31'b0, halted}, 32'd0);
        tick();
        chk("halt.halted", {31'b0, halted}, 32'd1);
        chk("halt.pc", pc, 32'h0);
        imem_data = 32'h2800_0010;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 1);
            tick();
            chk("halt.hold_halted", {31'b0, halted}, 32'd1);
            chk("halt.hold_pc", pc, 32'h0);
            chk("halt.hold_ir", ir, 32'hF800_0000);
            chk("halt.hold_strobes",
                {26'b0, reg_we, dmem_req, dmem_we, retire, illegal_op, alu_src_imm}, 32'd0);
        end
        dmem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt.rst_halted", {31'b0, halted}, 32'd0);
        chk("halt.rst_pc", pc, 32'h0);
        chk("halt.rst_ir", ir, 32'h0);

        // ALUR after reset: operand B never from imm
        fetchInstr("alur", 32'h0, 32'h0000_0123, 32'h0000_0123);
        chk("alur.exec_src", {31'b0, alu_src_imm}, 32'd0);
        tick();
        chk("alur.wb_we", {31'b0, reg_we}, 32'd1);
        chk("alur.wb_src", {31'b0, alu_src_imm}, 32'd0);
        tick();
        chk("alur.pc", pc, 32'h1);
        chk("alur.retire", {31'b0, retire}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
